// File: rtl/msx_slot_pkg.sv
// msx_slot_pkg: shared FSM state, layout-table entry type and expander address for msx_slot_decoder
package msx_slot_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, REQ, HOLD} state_t;
  localparam int BASE_W = 32;
  typedef struct packed {
    logic [BASE_W-1:0] base;
    logic              ro;
    logic              unmapped;
  } layout_entry_t;
  localparam logic [15:0] EXP_REG_ADDR = 16'hFFFF;
endpackage

// File: rtl/msx_slot_decoder_exp.sv
// slot_expander_regs: per-primary-slot subslot expander registers with readback and subslot select
module slot_expander_regs #(
  parameter int SLOTS = 4,
  localparam int SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [SLOT_W-1:0] slot,
  input  logic [7:0]        wdata,
  input  logic [1:0]        block,
  input  logic              en,
  output logic [7:0]        rdata,
  output logic [1:0]        sub
);
  logic [7:0] regs_q [SLOTS];
  always_ff @(posedge clk)
    if (reset) regs_q <= '{default: '0};
    else if (we) regs_q[slot] <= wdata;
  assign rdata = regs_q[slot];
  assign sub = en ? rdata[{block, 1'b0} +: 2] : 2'b00;
endmodule

// File: rtl/msx_slot_decoder.sv
// msx_slot_decoder: CPU slot/subslot/block decode and req/ack memory sequencing; SLOT_DECODER_TIMEOUT_EN adds a request timeout
module msx_slot_decoder
  import msx_slot_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int ADDR_W = 27,
  parameter int TIMEOUT = 255,
  localparam int SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_mreq,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [SLOT_W-1:0] active_slot,
  input  logic [SLOTS-1:0]  expander_en,
  output logic [SLOT_W+3:0] layout_id,
  input  logic [ADDR_W-1:0] layout_base,
  input  logic              layout_ro,
  input  logic              layout_unmapped,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_wait,
`ifdef SLOT_DECODER_TIMEOUT_EN
  output logic              timeout_flag,
`endif
  output logic [1:0]        subslot
);
  state_t state_q, state_d;
  logic acc_wr_q, acc_wr_d, abort_q, abort_d, wr_q;
  logic mem_we_q, mem_we_d, mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_din_q, mem_din_d, cpu_din_q, cpu_din_d, exp_rdata;
  logic [1:0] block;
  logic exp_sel, exp_hit, access, blocked, done, expire;
  layout_entry_t ent;
  logic unused_ent;
  assign block = cpu_addr[15:14];
  assign exp_sel = expander_en[active_slot];
  assign exp_hit = cpu_mreq && cpu_addr == EXP_REG_ADDR && exp_sel;
  assign access = cpu_mreq && (cpu_rd || cpu_wr) && !exp_hit;
  assign layout_id = {active_slot, subslot, block};
  assign ent = '{base: BASE_W'(layout_base), ro: layout_ro, unmapped: layout_unmapped};
  assign unused_ent = ^ent.base;
  assign blocked = ent.unmapped || (acc_wr_q && ent.ro);
  assign done = mem_ack || expire;
  slot_expander_regs #(.SLOTS(SLOTS)) u_exp (
    .clk(clk), .reset(reset), .we(exp_hit && cpu_wr && !wr_q), .slot(active_slot),
    .wdata(cpu_dout), .block(block), .en(exp_sel), .rdata(exp_rdata), .sub(subslot)
  );
`ifdef SLOT_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  assign expire = state_q == REQ && !mem_ack && cnt_q == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q <= '0;
      timeout_flag <= 1'b0;
    end else begin
      cnt_q <= state_q == REQ ? cnt_q + CNT_W'(1) : '0;
      timeout_flag <= timeout_flag || expire;
    end
`else
  localparam int unused_timeout = TIMEOUT;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    acc_wr_d = acc_wr_q;
    abort_d = abort_q;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    mem_we_d = mem_we_q;
    mem_req_d = mem_req_q;
    cpu_din_d = cpu_din_q;
    case (state_q)
      IDLE: if (access) begin
        state_d = LOOKUP;
        acc_wr_d = cpu_wr;
        abort_d = 1'b0;
      end
      LOOKUP:
        if (!cpu_mreq) state_d = IDLE;
        else if (blocked) state_d = HOLD;
        else begin
          state_d = REQ;
          mem_addr_d = ent.base[ADDR_W-1:0] + ADDR_W'(cpu_addr[13:0]);
          mem_din_d = cpu_dout;
          mem_we_d = acc_wr_q;
          mem_req_d = 1'b1;
        end
      REQ: begin
        // an aborted cycle still waits for the ack so the arbiter never sees a dangling request
        abort_d = abort_q || !cpu_mreq;
        if (done) begin
          state_d = abort_d ? IDLE : HOLD;
          mem_req_d = 1'b0;
          cpu_din_d = (mem_ack && !acc_wr_q && !abort_d) ? mem_dout : 8'hFF;
        end
      end
      default: if (!cpu_mreq) begin
        state_d = IDLE;
        cpu_din_d = 8'hFF;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      acc_wr_q <= 1'b0;
      abort_q <= 1'b0;
      wr_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      mem_we_q <= 1'b0;
      mem_req_q <= 1'b0;
      cpu_din_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      acc_wr_q <= acc_wr_d;
      abort_q <= abort_d;
      wr_q <= cpu_wr;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      mem_we_q <= mem_we_d;
      mem_req_q <= mem_req_d;
      cpu_din_q <= cpu_din_d;
    end
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
  assign mem_we = mem_we_q;
  assign mem_req = mem_req_q;
  assign cpu_din = exp_hit ? ~exp_rdata : cpu_din_q;
  assign cpu_wait = (state_q == IDLE && access) || state_q == LOOKUP || state_q == REQ;
endmodule

// File: tb/tb_msx_slot_decoder.sv
// tb_msx_slot_decoder: directed and randomized checks of msx_slot_decoder against a transaction-level model
module tb_msx_slot_decoder;
  localparam int SLOTS = 4, ADDR_W = 27, TIMEOUT = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_dout = '0, mem_dout = '0, mem_din, cpu_din;
  logic cpu_mreq = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0, mem_ack = 1'b0;
  logic [1:0] active_slot = '0, subslot;
  logic [3:0] expander_en = '0;
  logic [5:0] layout_id;
  logic [ADDR_W-1:0] layout_base = '0, mem_addr;
  logic layout_ro = 1'b0, layout_unmapped = 1'b0, mem_we, mem_req, cpu_wait;
`ifdef SLOT_DECODER_TIMEOUT_EN
  logic timeout_flag;
`endif
  logic [ADDR_W-1:0] tb_base [64];
  bit tb_ro [64];
  bit tb_un [64];
  logic [7:0] exp_m [4];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  msx_slot_decoder #(.SLOTS(SLOTS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_mreq(cpu_mreq),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .active_slot(active_slot), .expander_en(expander_en),
    .layout_id(layout_id), .layout_base(layout_base), .layout_ro(layout_ro),
    .layout_unmapped(layout_unmapped), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_dout(mem_dout), .cpu_din(cpu_din),
    .cpu_wait(cpu_wait),
`ifdef SLOT_DECODER_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .subslot(subslot)
  );

  // external layout table with one cycle of read latency
  always @(posedge clk) begin
    layout_base <= tb_base[layout_id];
    layout_ro <= tb_ro[layout_id];
    layout_unmapped <= tb_un[layout_id];
  end

  function automatic logic [5:0] model_id(input int s, input logic [15:0] a, input logic [3:0] en);
    int b = int'(a[15:14]);
    int sub = en[s] ? int'((exp_m[s] >> (2 * b)) & 8'd3) : 0;
    return 6'(s * 16 + sub * 4 + b);
  endfunction

  task automatic access(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] d,
                        input int dly, input logic [7:0] dout, output int w, output bit rq,
                        output logic [ADDR_W-1:0] ao, output logic wo, output logic [7:0] dno,
                        output logic [7:0] cdin, output logic [7:0] idin);
    int n, rc;
    cpu_addr = a; cpu_dout = d; cpu_rd = rd; cpu_wr = wr; cpu_mreq = 1'b1; mem_dout = dout;
    w = 0; rq = 0; ao = '0; wo = 1'b0; dno = '0; n = 0; rc = 0;
    #1;
    while (cpu_wait && n < 300) begin
      w++;
      if (mem_req) begin
        if (!rq) begin ao = mem_addr; wo = mem_we; dno = mem_din; end
        rq = 1;
        mem_ack = (rc == dly);
        rc++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      n++;
    end
    rq = rq | mem_req;
    @(posedge clk); #1;
    rq = rq | mem_req;
    cdin = cpu_din;
    cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(posedge clk); #1;
    idin = cpu_din;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if (cpu_din !== 8'hFF) begin bad++; $display("FAIL reset_din got=%h exp=ff", cpu_din); end
    total++; if (cpu_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b exp=0", cpu_wait); end
`ifdef SLOT_DECODER_TIMEOUT_EN
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset_tflag got=%b exp=0", timeout_flag); end
`endif
    reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_m[i] = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_expander;
    int w; bit rq; logic [ADDR_W-1:0] ao; logic wo; logic [7:0] dn, cd, id;
    active_slot = 2'd3; expander_en = 4'b1000;
    access(16'hFFFF, 1'b0, 1'b1, 8'hE4, 0, 8'h00, w, rq, ao, wo, dn, cd, id);
    exp_m[3] = 8'hE4;
    total++; if (rq !== 1'b0 || w !== 0) begin bad++; $display("FAIL exp_write req=%b wait=%0d exp req=0 wait=0", rq, w); end
    access(16'hFFFF, 1'b1, 1'b0, 8'h00, 0, 8'h00, w, rq, ao, wo, dn, cd, id);
    total++; if (cd !== 8'h1B) begin bad++; $display("FAIL exp_read got=%h exp=1b", cd); end
    total++; if (rq !== 1'b0 || w !== 0) begin bad++; $display("FAIL exp_read_req req=%b wait=%0d exp req=0 wait=0", rq, w); end
    cpu_addr = 16'h4000; #1;
    total++; if (layout_id !== 6'(3 * 16 + 1 * 4 + 1)) begin bad++; $display("FAIL exp_layout_id got=%h exp=%h", layout_id, 6'(53)); end
    total++; if (subslot !== 2'd1) begin bad++; $display("FAIL exp_subslot got=%0d exp=1", subslot); end
    cpu_addr = 16'h0000;
  endtask

  task automatic test_mapped_read;
    int w; bit rq; logic [ADDR_W-1:0] ao; logic wo; logic [7:0] dn, cd, id;
    active_slot = 2'd0; expander_en = 4'b0000;
    tb_base[1] = 27'h10000; tb_ro[1] = 0; tb_un[1] = 0;
    access(16'h4123, 1'b1, 1'b0, 8'h00, 1, 8'h5A, w, rq, ao, wo, dn, cd, id);
    total++; if (ao !== 27'h10123) begin bad++; $display("FAIL rd_addr got=%h exp=10123", ao); end
    total++; if (rq !== 1'b1 || wo !== 1'b0) begin bad++; $display("FAIL rd_req req=%b we=%b exp req=1 we=0", rq, wo); end
    total++; if (cd !== 8'h5A) begin bad++; $display("FAIL rd_data got=%h exp=5a", cd); end
    total++; if (w !== 4) begin bad++; $display("FAIL rd_wait got=%0d exp=4", w); end
    total++; if (id !== 8'hFF) begin bad++; $display("FAIL rd_idle_din got=%h exp=ff", id); end
    tb_base[2] = 27'h7FFC000; tb_ro[2] = 0; tb_un[2] = 0;
    access(16'hBFFF, 1'b0, 1'b1, 8'h3C, 0, 8'h11, w, rq, ao, wo, dn, cd, id);
    total++; if (w !== 3) begin bad++; $display("FAIL wr_min_wait got=%0d exp=3", w); end
    total++; if (ao !== 27'h7FFFFFF || wo !== 1'b1 || dn !== 8'h3C) begin bad++; $display("FAIL wr_fields addr=%h we=%b din=%h exp 7ffffff 1 3c", ao, wo, dn); end
    total++; if (cd !== 8'hFF) begin bad++; $display("FAIL wr_cpu_din got=%h exp=ff", cd); end
  endtask

  task automatic test_ro_unmapped;
    int w; bit rq; logic [ADDR_W-1:0] ao; logic wo; logic [7:0] dn, cd, id;
    active_slot = 2'd0; expander_en = 4'b0000;
    tb_ro[2] = 1;
    access(16'h8000, 1'b0, 1'b1, 8'h77, 0, 8'h00, w, rq, ao, wo, dn, cd, id);
    total++; if (rq !== 1'b0) begin bad++; $display("FAIL ro_req got=%b exp=0", rq); end
    total++; if (w !== 2) begin bad++; $display("FAIL ro_wait got=%0d exp=2", w); end
    tb_un[0] = 1;
    access(16'h0123, 1'b1, 1'b0, 8'h00, 0, 8'h42, w, rq, ao, wo, dn, cd, id);
    total++; if (cd !== 8'hFF || rq !== 1'b0) begin bad++; $display("FAIL unmapped din=%h req=%b exp ff 0", cd, rq); end
    total++; if (w !== 2) begin bad++; $display("FAIL unmapped_wait got=%0d exp=2", w); end
    tb_ro[2] = 0; tb_un[0] = 0;
  endtask

  task automatic test_exp_disabled;
    int w; bit rq; logic [ADDR_W-1:0] ao; logic wo; logic [7:0] dn, cd, id;
    active_slot = 2'd0; expander_en = 4'b1000;
    tb_base[3] = 27'h2000; tb_ro[3] = 0; tb_un[3] = 0;
    access(16'hFFFF, 1'b0, 1'b1, 8'hAA, 0, 8'h00, w, rq, ao, wo, dn, cd, id);
    total++; if (rq !== 1'b1 || wo !== 1'b1 || dn !== 8'hAA) begin bad++; $display("FAIL expdis_req req=%b we=%b din=%h exp 1 1 aa", rq, wo, dn); end
    total++; if (ao !== 27'h5FFF) begin bad++; $display("FAIL expdis_addr got=%h exp=5fff", ao); end
    expander_en = 4'b1001;
    access(16'hFFFF, 1'b1, 1'b0, 8'h00, 0, 8'h00, w, rq, ao, wo, dn, cd, id);
    total++; if (cd !== ~exp_m[0]) begin bad++; $display("FAIL expdis_reg0 got=%h exp=%h", cd, ~exp_m[0]); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int w; bit rq; logic [ADDR_W-1:0] ao; logic wo; logic [7:0] dn, cd, id;
    active_slot = 2'd0; expander_en = 4'b0000; tb_un[1] = 0; tb_ro[1] = 0;
    cpu_addr = 16'h4000; cpu_rd = 1'b1; cpu_mreq = 1'b1;
    #1;
    while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_reach_req got=%b exp=1", mem_req); end
    reset = 1'b1; cpu_mreq = 1'b0; cpu_rd = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0; reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_m[i] = 8'h00;
    total++; if (mem_req !== 1'b0 || cpu_wait !== 1'b0) begin bad++; $display("FAIL mid_reset req=%b wait=%b exp 0 0", mem_req, cpu_wait); end
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b0 || cpu_din !== 8'hFF) begin bad++; $display("FAIL mid_after req=%b din=%h exp 0 ff", mem_req, cpu_din); end
    active_slot = 2'd3; expander_en = 4'b1000;
    access(16'hFFFF, 1'b1, 1'b0, 8'h00, 0, 8'h00, w, rq, ao, wo, dn, cd, id);
    total++; if (cd !== 8'hFF) begin bad++; $display("FAIL mid_expreg got=%h exp=ff", cd); end
  endtask

`ifdef SLOT_DECODER_TIMEOUT_EN
  task automatic test_timeout;
    int w; bit rq; logic [ADDR_W-1:0] ao; logic wo; logic [7:0] dn, cd, id;
    active_slot = 2'd0; expander_en = 4'b0000; tb_un[1] = 0; tb_ro[1] = 0;
    access(16'h4001, 1'b1, 1'b0, 8'h00, -1, 8'h99, w, rq, ao, wo, dn, cd, id);
    total++; if (w !== 2 + TIMEOUT || rq !== 1'b1) begin bad++; $display("FAIL timeout_wait wait=%0d req=%b exp %0d 1", w, rq, 2 + TIMEOUT); end
    total++; if (cd !== 8'hFF) begin bad++; $display("FAIL timeout_din got=%h exp=ff", cd); end
    total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b exp=1", timeout_flag); end
  endtask
`endif

  task automatic test_random;
    int w, e_w, dly; bit rq, e_rq, blk; logic [ADDR_W-1:0] ao, e_ao; logic wo; logic [7:0] dn, cd, id, e_cd, d, dout;
    logic [15:0] a; logic [3:0] en; logic [1:0] r; int s; logic [5:0] lid;
    for (int i = 0; i < 64; i++) begin
      tb_base[i] = ADDR_W'($urandom); tb_ro[i] = ($urandom_range(0, 3) == 0); tb_un[i] = ($urandom_range(0, 7) == 0);
    end
    for (int k = 0; k < 60; k++) begin
      s = $urandom_range(0, 3); en = 4'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      r = 2'($urandom_range(1, 3)); d = 8'($urandom); dout = 8'($urandom); dly = $urandom_range(0, 3);
      active_slot = 2'(s); expander_en = en;
      if (a == 16'hFFFF && en[s]) begin
        if (r[1]) exp_m[s] = d;
        e_w = 0; e_rq = 0; e_ao = '0; e_cd = ~exp_m[s];
      end else begin
        lid = model_id(s, a, en);
        blk = tb_un[lid] || (r[1] && tb_ro[lid]);
        e_w = blk ? 2 : 3 + dly; e_rq = !blk;
        e_ao = tb_base[lid] + ADDR_W'(a[13:0]);
        e_cd = (blk || r[1]) ? 8'hFF : dout;
      end
      access(a, r[0], r[1], d, dly, dout, w, rq, ao, wo, dn, cd, id);
      total++; if (w !== e_w || rq !== e_rq) begin bad++; $display("FAIL rnd%0d_wait wait=%0d req=%b exp %0d %b", k, w, rq, e_w, e_rq); end
      total++; if (cd !== e_cd) begin bad++; $display("FAIL rnd%0d_din got=%h exp=%h", k, cd, e_cd); end
      total++; if (id !== 8'hFF) begin bad++; $display("FAIL rnd%0d_idle got=%h exp=ff", k, id); end
      if (e_rq) begin
        total++; if (ao !== e_ao || wo !== r[1] || dn !== d) begin bad++; $display("FAIL rnd%0d_mem addr=%h we=%b din=%h exp %h %b %h", k, ao, wo, dn, e_ao, r[1], d); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin tb_base[i] = '0; tb_ro[i] = 0; tb_un[i] = 0; end
    test_reset();
    test_expander();
    test_mapped_read();
    test_ro_unmapped();
    test_exp_disabled();
    test_reset_mid();
`ifdef SLOT_DECODER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
